// File: rtl/sva_pkg.sv
// Shared types and defaults for the SVA verdict collector.
// verdict_t is the window summary layout consumers decode from verdict_data.
package sva_pkg;

    localparam int SVA_CNT_W_DEF      = 16;
    localparam int SVA_TIMER_W_DEF    = 8;
    localparam int SVA_FIFO_DEPTH_DEF = 4;

    // Window summary: period index at window open plus sticky verdict flags.
    typedef struct packed {
        logic [SVA_TIMER_W_DEF-1:0] period;
        logic                       any_lazy;
        logic                       any_fail;
        logic                       any_succ;
    } verdict_t;

    // Window controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no window open
        ST_OPEN  = 2'd1,   // window accumulating verdicts
        ST_CLOSE = 2'd2    // push finished window, new one already collecting
    } ctrl_state_e;

endpackage

// File: rtl/sva_verdict_fifo.sv
// Small circular queue for window summaries.
// A push on a full queue is accepted only when a pop happens in the same cycle.
module sva_verdict_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is clean after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sva_verdict_collector.sv
// Collects assertion checker verdicts: saturating counts, first-fail period,
// and (with SVA_VERDICT_STREAM_EN defined) a per-gclk-window summary stream
// through a small queue. Without the macro the stream outputs are tied off.
module sva_verdict_collector
    import sva_pkg::*;
#(
    parameter int CNT_WIDTH   = SVA_CNT_W_DEF,
    parameter int TIMER_WIDTH = SVA_TIMER_W_DEF,
    parameter int FIFO_DEPTH  = SVA_FIFO_DEPTH_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   succ,
    input  logic                   fail,
    input  logic                   lazy_succ,
    output logic [CNT_WIDTH-1:0]   succ_cnt,
    output logic [CNT_WIDTH-1:0]   fail_cnt,
    output logic [CNT_WIDTH-1:0]   lazy_cnt,
    output logic                   first_fail_valid,
    output logic [TIMER_WIDTH-1:0] first_fail_period,
    output logic                   verdict_valid,
    input  logic                   verdict_ready,
    output logic [TIMER_WIDTH+2:0] verdict_data,
    output logic                   overflow
);

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = 1;

    logic                   gclk_d0;
    logic                   gclk_d1;
    logic                   gclk_posedge_flag;
    logic [TIMER_WIDTH-1:0] period;
    logic [2:0]             verdicts;

    assign gclk_posedge_flag = gclk_d0 & ~gclk_d1;
    assign verdicts          = {lazy_succ, fail, succ};

    // Two-flop sampler of the user clock; grst flushes it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gclk_d0 <= 1'b0;
            gclk_d1 <= 1'b0;
        end else if (grst) begin
            gclk_d0 <= 1'b0;
            gclk_d1 <= 1'b0;
        end else begin
            gclk_d0 <= gclk;
            gclk_d1 <= gclk_d0;
        end
    end

    // gclk period index, wraps naturally.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)             period <= '0;
        else if (grst)              period <= '0;
        else if (gclk_posedge_flag) period <= period + TIMER_ONE;
    end

    // Saturating verdict counters; simultaneous verdicts each count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
        end else if (grst) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
        end else begin
            if (succ      && succ_cnt != '1) succ_cnt <= succ_cnt + CNT_ONE;
            if (fail      && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
            if (lazy_succ && lazy_cnt != '1) lazy_cnt <= lazy_cnt + CNT_ONE;
        end
    end

    // Sticky first-fail capture; later fails leave the period alone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            first_fail_valid  <= 1'b0;
            first_fail_period <= '0;
        end else if (grst) begin
            first_fail_valid  <= 1'b0;
            first_fail_period <= '0;
        end else if (fail && !first_fail_valid) begin
            first_fail_valid  <= 1'b1;
            first_fail_period <= period;
        end
    end

`ifdef SVA_VERDICT_STREAM_EN
    ctrl_state_e            state;
    ctrl_state_e            state_nxt;
    logic [2:0]             acc;
    logic [2:0]             acc_nxt;
    logic [TIMER_WIDTH-1:0] win_period;
    logic [TIMER_WIDTH-1:0] win_period_nxt;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign verdict_valid = !fifo_empty;
    assign pop           = verdict_valid && verdict_ready;

    // Window controller state and accumulator registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            win_period <= '0;
        end else if (grst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            win_period <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            win_period <= win_period_nxt;
        end
    end

    // Window sequencing: the closing flag cycle still counts for the old
    // window; the CLOSE cycle's verdicts seed the next one.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        win_period_nxt = win_period;
        push           = 1'b0;
        case (state)
            ST_IDLE: begin
                acc_nxt = '0;
                if (gclk_posedge_flag) begin
                    state_nxt      = ST_OPEN;
                    win_period_nxt = period + TIMER_ONE;
                end
            end
            ST_OPEN: begin
                acc_nxt = acc | verdicts;
                if (gclk_posedge_flag) state_nxt = ST_CLOSE;
            end
            ST_CLOSE: begin
                push           = |acc;
                acc_nxt        = verdicts;
                win_period_nxt = period;
                state_nxt      = ST_OPEN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sticky overflow: a summary lost to a full queue with no pop to make room.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       overflow <= 1'b0;
        else if (grst)                        overflow <= 1'b0;
        else if (push && fifo_full && !pop)   overflow <= 1'b1;
    end

    sva_verdict_fifo #(
        .W     (TIMER_WIDTH + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .clr       (grst),
        .push      (push),
        .push_data ({win_period, acc}),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .pop_data  (verdict_data)
    );
`else
    logic unused_verdict_ready;

    assign unused_verdict_ready = verdict_ready;
    assign verdict_valid        = 1'b0;
    assign verdict_data         = '0;
    assign overflow             = 1'b0;
`endif

endmodule

// File: tb/tb_sva_verdict_collector.sv
// Randomized and directed checks of sva_verdict_collector against a
// cycle-level behavioural model (counts, first fail, window queue).
module tb_sva_verdict_collector;

    localparam int CW    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          gclk, grst, succ, fail, lazy_succ, verdict_ready;
    logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt;
    logic          first_fail_valid;
    logic [TW-1:0] first_fail_period;
    logic          verdict_valid;
    logic [TW+2:0] verdict_data;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int            m_succ, m_fail, m_lazy;
    bit            m_ffv;
    logic [TW-1:0] m_ffp, m_period, m_tag;
    bit            m_g1, m_g2, m_open, m_pend, m_ovf;
    logic [2:0]    m_w;
    logic [TW+2:0] m_pdata;
    logic [TW+2:0] q[$];

    sva_verdict_collector #(.CNT_WIDTH(CW), .TIMER_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .grst(grst),
        .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
        .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_period(first_fail_period),
        .verdict_valid(verdict_valid), .verdict_ready(verdict_ready),
        .verdict_data(verdict_data), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_clear();
        m_succ = 0; m_fail = 0; m_lazy = 0; m_ffv = 0; m_ffp = '0; m_period = '0;
        m_tag = '0; m_g1 = 0; m_g2 = 0; m_open = 0; m_pend = 0; m_ovf = 0; m_w = '0;
        m_pdata = '0; q.delete();
    endtask

    // One sys_clk edge of the reference behaviour, using the inputs seen at the edge.
    task automatic model_step();
        bit flag;
        logic [2:0] v;
        if (!sys_rst_n || grst) begin model_clear(); return; end
        flag = m_g1 && !m_g2;
        v = {lazy_succ, fail, succ};
        if (succ)      m_succ = (m_succ < CMAX) ? m_succ + 1 : CMAX;
        if (fail)      m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
        if (lazy_succ) m_lazy = (m_lazy < CMAX) ? m_lazy + 1 : CMAX;
        if (fail && !m_ffv) begin m_ffv = 1; m_ffp = m_period; end
        if (q.size() != 0 && verdict_ready) void'(q.pop_front());
        if (m_pend) begin
            if (q.size() < DEPTH) q.push_back(m_pdata); else m_ovf = 1;
        end
        m_pend = 0;
        if (m_open) begin
            m_w = m_w | v;
            if (flag) begin
                if (m_w != 0) begin m_pend = 1; m_pdata = {m_tag, m_w}; end
                m_w = '0;
                m_tag = m_period + 1'b1;
            end
        end else if (flag) begin
            m_open = 1; m_w = '0; m_tag = m_period + 1'b1;
        end
        if (flag) m_period = m_period + 1'b1;
        m_g2 = m_g1; m_g1 = gclk;
    endtask

    function automatic logic exp_valid();
`ifdef SVA_VERDICT_STREAM_EN
        return q.size() != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [TW+2:0] exp_data();
`ifdef SVA_VERDICT_STREAM_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return '0;
`endif
    endfunction

    function automatic logic exp_ovf();
`ifdef SVA_VERDICT_STREAM_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic gclk_pulse();
        gclk = 1'b1; repeat (3) tick();
        gclk = 1'b0; repeat (3) tick();
    endtask

    task automatic do_grst();
        grst = 1'b1; tick(); grst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; model_clear(); tick(); tick();
        total++; if (succ_cnt !== '0) begin bad++; $display("FAIL rst_succ_cnt got=%0d exp=0", succ_cnt); end
        total++; if (fail_cnt !== '0) begin bad++; $display("FAIL rst_fail_cnt got=%0d exp=0", fail_cnt); end
        total++; if (lazy_cnt !== '0) begin bad++; $display("FAIL rst_lazy_cnt got=%0d exp=0", lazy_cnt); end
        total++; if ({first_fail_valid, first_fail_period} !== '0) begin bad++; $display("FAIL rst_first_fail got=%0d/%0d exp=0/0", first_fail_valid, first_fail_period); end
        total++; if ({verdict_valid, verdict_data, overflow} !== '0) begin bad++; $display("FAIL rst_stream got v=%0b d=%h o=%0b exp all 0", verdict_valid, verdict_data, overflow); end
        sys_rst_n = 1'b1; tick();
    endtask

    task automatic test_first_fail();
        do_grst();
        repeat (5) gclk_pulse();
        repeat (3) begin succ = 1'b1; tick(); succ = 1'b0; tick(); end
        repeat (2) begin fail = 1'b1; tick(); fail = 1'b0; tick(); end
        gclk_pulse();
        fail = 1'b1; tick(); fail = 1'b0; tick();
        total++; if (succ_cnt !== 4'd3) begin bad++; $display("FAIL ff_succ_cnt got=%0d exp=3", succ_cnt); end
        total++; if (fail_cnt !== 4'd3) begin bad++; $display("FAIL ff_fail_cnt got=%0d exp=3", fail_cnt); end
        total++; if (first_fail_valid !== 1'b1) begin bad++; $display("FAIL ff_valid got=%0b exp=1", first_fail_valid); end
        total++; if (first_fail_period !== 8'd5) begin bad++; $display("FAIL ff_period got=%0d exp=5", first_fail_period); end
    endtask

    task automatic test_saturation();
        do_grst();
        repeat (20) begin succ = 1'b1; lazy_succ = 1'b1; tick(); end
        succ = 1'b0; lazy_succ = 1'b0;
        total++; if (succ_cnt !== 4'd15) begin bad++; $display("FAIL sat_succ got=%0d exp=15", succ_cnt); end
        total++; if (lazy_cnt !== 4'd15) begin bad++; $display("FAIL sat_lazy got=%0d exp=15", lazy_cnt); end
        succ = 1'b1; repeat (3) tick(); succ = 1'b0; tick();
        total++; if (succ_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", succ_cnt); end
    endtask

    task automatic test_same_cycle();
        do_grst();
        verdict_ready = 1'b0;
        gclk_pulse();
        succ = 1'b1; fail = 1'b1; tick(); succ = 1'b0; fail = 1'b0;
        gclk_pulse();
        total++; if ({succ_cnt, fail_cnt} !== {4'd1, 4'd1}) begin bad++; $display("FAIL same_cnt got=%0d/%0d exp=1/1", succ_cnt, fail_cnt); end
        total++; if (verdict_data !== exp_data()) begin bad++; $display("FAIL same_data got=%h exp=%h", verdict_data, exp_data()); end
`ifdef SVA_VERDICT_STREAM_EN
        total++; if (verdict_data !== {8'd1, 3'b011}) begin bad++; $display("FAIL same_summary got=%h exp=%h", verdict_data, {8'd1, 3'b011}); end
`endif
    endtask

    task automatic test_overflow();
        do_grst();
        verdict_ready = 1'b0;
        gclk_pulse();
        for (int k = 0; k < 5; k++) begin
            succ = 1'b1; tick(); succ = 1'b0;
            gclk_pulse();
        end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        total++; if (verdict_data !== {8'd1, 3'b001}) begin bad++; $display("FAIL ovf_hold got=%h exp=%h", verdict_data, {8'd1, 3'b001}); end
        verdict_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (verdict_valid !== 1'b1 || verdict_data[TW+2:3] !== TW'(k + 1)) begin bad++; $display("FAIL ovf_pop%0d got v=%0b p=%0d exp v=1 p=%0d", k, verdict_valid, verdict_data[TW+2:3], k + 1); end
            tick();
        end
        total++; if (verdict_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%0b exp=0", verdict_valid); end
        verdict_ready = 1'b0;
    endtask

    task automatic test_grst_mid_window();
        do_grst();
        verdict_ready = 1'b0;
        gclk_pulse();
        succ = 1'b1; tick(); succ = 1'b0; gclk_pulse();
        fail = 1'b1; tick(); fail = 1'b0; gclk_pulse();
        lazy_succ = 1'b1; tick(); lazy_succ = 1'b0;
        total++; if (verdict_valid !== exp_valid()) begin bad++; $display("FAIL grst_pre_valid got=%0b exp=%0b", verdict_valid, exp_valid()); end
        do_grst();
        total++; if ({succ_cnt, fail_cnt, lazy_cnt} !== '0) begin bad++; $display("FAIL grst_cnts got=%0d/%0d/%0d exp=0", succ_cnt, fail_cnt, lazy_cnt); end
        total++; if (verdict_valid !== 1'b0) begin bad++; $display("FAIL grst_valid got=%0b exp=0", verdict_valid); end
        total++; if (first_fail_valid !== 1'b0) begin bad++; $display("FAIL grst_ffv got=%0b exp=0", first_fail_valid); end
        gclk_pulse(); gclk_pulse(); tick();
        total++; if (verdict_valid !== 1'b0) begin bad++; $display("FAIL grst_no_summary got=%0b exp=0", verdict_valid); end
    endtask

    task automatic test_random();
        int gcnt;
        do_grst();
        gcnt = 2;
        for (int n = 0; n < 600; n++) begin
            succ          = ($urandom % 4) == 0;
            fail          = ($urandom % 6) == 0;
            lazy_succ     = ($urandom % 5) == 0;
            verdict_ready = ($urandom % 3) == 0;
            grst          = ($urandom % 150) == 0;
            if (gcnt == 0) begin gclk = ~gclk; gcnt = $urandom_range(2, 7); end
            else gcnt--;
            tick();
            total++; if (succ_cnt !== CW'(m_succ) || fail_cnt !== CW'(m_fail) || lazy_cnt !== CW'(m_lazy)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, succ_cnt, fail_cnt, lazy_cnt, m_succ, m_fail, m_lazy); end
            total++; if (first_fail_valid !== m_ffv || first_fail_period !== m_ffp) begin bad++; $display("FAIL rnd_ff n=%0d got=%0b/%0d exp=%0b/%0d", n, first_fail_valid, first_fail_period, m_ffv, m_ffp); end
            total++; if (verdict_valid !== exp_valid() || verdict_data !== exp_data()) begin bad++; $display("FAIL rnd_stream n=%0d got=%0b/%h exp=%0b/%h", n, verdict_valid, verdict_data, exp_valid(), exp_data()); end
            total++; if (overflow !== exp_ovf()) begin bad++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, overflow, exp_ovf()); end
        end
        {succ, fail, lazy_succ, grst, verdict_ready, gclk} = '0;
        tick();
    endtask

    task automatic test_async_reset();
        do_grst();
        verdict_ready = 1'b0;
        gclk_pulse();
        for (int k = 0; k < 5; k++) begin
            fail = 1'b1; succ = 1'b1; tick(); fail = 1'b0; succ = 1'b0;
            gclk_pulse();
        end
        total++; if (overflow !== exp_ovf() || verdict_valid !== exp_valid()) begin bad++; $display("FAIL ar_pre got o=%0b v=%0b exp o=%0b v=%0b", overflow, verdict_valid, exp_ovf(), exp_valid()); end
        #3 sys_rst_n = 1'b0;
        #1;
        model_clear();
        total++; if ({succ_cnt, fail_cnt, lazy_cnt, first_fail_valid, first_fail_period} !== '0) begin bad++; $display("FAIL ar_core got=%0d/%0d/%0d/%0b/%0d exp=0", succ_cnt, fail_cnt, lazy_cnt, first_fail_valid, first_fail_period); end
        total++; if ({verdict_valid, verdict_data, overflow} !== '0) begin bad++; $display("FAIL ar_stream got v=%0b d=%h o=%0b exp all 0", verdict_valid, verdict_data, overflow); end
        tick();
        sys_rst_n = 1'b1;
        gclk_pulse();
        succ = 1'b1; tick(); succ = 1'b0;
        gclk_pulse(); tick();
        total++; if (verdict_valid !== exp_valid() || verdict_data !== exp_data() || succ_cnt !== CW'(m_succ)) begin bad++; $display("FAIL ar_after got v=%0b d=%h s=%0d exp v=%0b d=%h s=%0d", verdict_valid, verdict_data, succ_cnt, exp_valid(), exp_data(), m_succ); end
    endtask

    initial begin
        {gclk, grst, succ, fail, lazy_succ, verdict_ready} = '0;
        sys_rst_n = 1'b0;
        model_clear();
        test_reset();
        test_first_fail();
        test_saturation();
        test_same_cycle();
`ifdef SVA_VERDICT_STREAM_EN
        test_overflow();
`endif
        test_grst_mid_window();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
